// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory responder for the CPU memory port; bad addresses are flagged, never applied.
// Latency: reads READ_LATENCY edges (registered Dataout); write ack one cycle after the sampling edge.
// Backpressure: none; accepts one access every cycle and the read pipeline never stalls.
module mem_responder #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Valid,
    output logic        WrAck,
    output logic        AddrErr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic          misaligned;
    logic          out_of_range;
    logic          bad_addr;
    logic          rd_req;
    logic          wr_req;

    logic          s1_vld;
    logic          s1_err;
    logic [31:0]   s1_dat;

    logic          tail_vld;
    logic          tail_err;
    logic [31:0]   tail_dat;

    logic          wr_err_sticky;

    assign word_idx     = Address[2 +: AW];
    assign misaligned   = (Address[1:0] != 2'b00);
    assign out_of_range = (Address[31:2+AW] != '0);
    assign bad_addr     = misaligned | out_of_range;
    assign rd_req       = req & ~wr;
    assign wr_req       = req & wr;

    // Stage-1 capture: a rejected read carries zero data so nothing leaks from the array.
    assign s1_vld = rd_req;
    assign s1_err = bad_addr;
    assign s1_dat = bad_addr ? 32'h0 : mem[word_idx];

    // Array contents deliberately survive reset.
    always_ff @(posedge Clk) begin
        if (!reset && wr_req && !bad_addr) begin
            mem[word_idx] <= Datain;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign tail_vld = s1_vld;
            assign tail_err = s1_err;
            assign tail_dat = s1_dat;
        end else begin : g_pipe
            localparam int NS = READ_LATENCY - 1;

            logic [NS-1:0] pv;
            logic [NS-1:0] pe;
            logic [31:0]   pd [NS];

            always_ff @(posedge Clk or posedge reset) begin
                if (reset) begin
                    pv <= '0;
                    pe <= '0;
                    for (int i = 0; i < NS; i++) begin
                        pd[i] <= 32'h0;
                    end
                end else begin
                    pv[0] <= s1_vld;
                    pe[0] <= s1_err;
                    pd[0] <= s1_dat;
                    for (int i = 1; i < NS; i++) begin
                        pv[i] <= pv[i-1];
                        pe[i] <= pe[i-1];
                        pd[i] <= pd[i-1];
                    end
                end
            end

            assign tail_vld = pv[NS-1];
            assign tail_err = pe[NS-1];
            assign tail_dat = pd[NS-1];
        end
    endgenerate

    // Final stage doubles as the output register; when a read and a write ack coincide, AddrErr follows the read.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            Dataout       <= 32'h0;
            Valid         <= 1'b0;
            WrAck         <= 1'b0;
            AddrErr       <= 1'b0;
            wr_err_sticky <= 1'b0;
        end else begin
            Valid <= tail_vld;
            WrAck <= wr_req;
            if (tail_vld) begin
                Dataout <= tail_dat;
            end
            if (tail_vld) begin
                AddrErr <= tail_err;
            end else if (wr_req) begin
                AddrErr <= bad_addr;
            end else begin
                AddrErr <= 1'b0;
            end
            wr_err_sticky <= wr_err_sticky | (tail_vld & wr_req & bad_addr);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (READ_LATENCY 1..4) share one random/directed stimulus stream
// and are checked every cycle against a per-edge transaction history plus a flat word-array model.
module tb_mem_responder;

    localparam int HN = 4096;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Datain = 32'h0;

    logic [31:0] d1, d2, d3, d4;
    logic        v1, v2, v3, v4;
    logic        a1, a2, a3, a4;
    logic        e1, e2, e3, e4;

    logic [31:0] dut_d [1:4];
    logic        dut_v [1:4];
    logic        dut_a [1:4];
    logic        dut_e [1:4];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(1)) u1 (
        .Clk(Clk), .reset(reset), .req(req), .wr(wr), .Address(Address), .Datain(Datain),
        .Dataout(d1), .Valid(v1), .WrAck(a1), .AddrErr(e1));
    mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2)) u2 (
        .Clk(Clk), .reset(reset), .req(req), .wr(wr), .Address(Address), .Datain(Datain),
        .Dataout(d2), .Valid(v2), .WrAck(a2), .AddrErr(e2));
    mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(3)) u3 (
        .Clk(Clk), .reset(reset), .req(req), .wr(wr), .Address(Address), .Datain(Datain),
        .Dataout(d3), .Valid(v3), .WrAck(a3), .AddrErr(e3));
    mem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(4)) u4 (
        .Clk(Clk), .reset(reset), .req(req), .wr(wr), .Address(Address), .Datain(Datain),
        .Dataout(d4), .Valid(v4), .WrAck(a4), .AddrErr(e4));

    assign dut_d[1] = d1; assign dut_d[2] = d2; assign dut_d[3] = d3; assign dut_d[4] = d4;
    assign dut_v[1] = v1; assign dut_v[2] = v2; assign dut_v[3] = v3; assign dut_v[4] = v4;
    assign dut_a[1] = a1; assign dut_a[2] = a2; assign dut_a[3] = a3; assign dut_a[4] = a4;
    assign dut_e[1] = e1; assign dut_e[2] = e2; assign dut_e[3] = e3; assign dut_e[4] = e4;

    // Reference model: what each sampling edge asked for, and the memory as the spec defines it.
    logic [31:0] mem_m [256];
    bit          h_rv [HN];
    bit          h_re [HN];
    bit          h_wv [HN];
    bit          h_we [HN];
    logic [31:0] h_rd [HN];
    logic [31:0] last_d [1:4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    int          ecnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge Clk) begin : model_edge
        int  s;
        bit  bad;
        ecnt++;
        s = ecnt % HN;
        h_rv[s] = 1'b0;
        h_re[s] = 1'b0;
        h_wv[s] = 1'b0;
        h_we[s] = 1'b0;
        h_rd[s] = 32'h0;
        if (!reset && req) begin
            bad = (Address[1:0] != 2'b00) || (Address[31:2] >= 30'd256);
            if (wr) begin
                h_wv[s] = 1'b1;
                h_we[s] = bad;
                if (!bad) mem_m[Address[9:2]] = Datain;
            end else begin
                h_rv[s] = 1'b1;
                h_re[s] = bad;
                h_rd[s] = bad ? 32'h0 : mem_m[Address[9:2]];
            end
        end
    end

    always @(posedge reset) begin
        for (int i = 0; i < HN; i++) begin
            h_rv[i] = 1'b0;
            h_wv[i] = 1'b0;
        end
        for (int l = 1; l <= 4; l++) last_d[l] = 32'h0;
    end

    always @(negedge Clk) begin
        for (int l = 1; l <= 4; l++) begin
            int idx;
            bit ev, ea, ee;
            idx = ecnt - l + 1;
            ev  = (idx > 0) && h_rv[idx % HN];
            ea  = (ecnt > 0) && h_wv[ecnt % HN];
            ee  = ev ? h_re[idx % HN] : (ea ? h_we[ecnt % HN] : 1'b0);
            if (ev) last_d[l] = h_rd[idx % HN];
            chk($sformatf("L%0d Valid", l),   {31'h0, dut_v[l]}, {31'h0, ev});
            chk($sformatf("L%0d WrAck", l),   {31'h0, dut_a[l]}, {31'h0, ea});
            chk($sformatf("L%0d AddrErr", l), {31'h0, dut_e[l]}, {31'h0, ee});
            chk($sformatf("L%0d Dataout", l), dut_d[l], last_d[l]);
        end
    end

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req = r; wr = w; Address = a; Datain = d;
        @(posedge Clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ra;
        #1 reset = 1'b1;
        #1;
        for (int l = 1; l <= 4; l++) begin
            chk($sformatf("reset L%0d Dataout", l), dut_d[l], 32'h0);
            chk($sformatf("reset L%0d flags", l), {29'h0, dut_v[l], dut_a[l], dut_e[l]}, 32'h0);
        end
        @(posedge Clk);
        #2 reset = 1'b0;

        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 32'(i * 4), $urandom);

        // Write then read at latency 1
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("wr ack", {31'h0, a1}, 32'h1);
        chk("wr ack err", {31'h0, e1}, 32'h0);
        step(1'b1, 1'b0, 32'h10, 32'h0);
        chk("rd valid", {31'h0, v1}, 32'h1);
        chk("rd data", d1, 32'hDEADBEEF);

        // Misaligned write into the same word must not land; out-of-range read
        step(1'b1, 1'b1, 32'h13, 32'h11111111);
        chk("misal ack", {31'h0, a1}, 32'h1);
        chk("misal err", {31'h0, e1}, 32'h1);
        step(1'b1, 1'b0, 32'h10, 32'h0);
        chk("misal unchanged", d1, 32'hDEADBEEF);
        step(1'b1, 1'b0, 32'h400, 32'h0);
        chk("oor valid", {31'h0, v1}, 32'h1);
        chk("oor err", {31'h0, e1}, 32'h1);
        chk("oor data", d1, 32'h0);

        // Pipelined reads at latency 3
        step(1'b1, 1'b1, 32'h0, 32'h1);
        step(1'b1, 1'b1, 32'h4, 32'h2);
        step(1'b1, 1'b1, 32'h8, 32'h3);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h4, 32'h0);
        chk("L3 early", {31'h0, v3}, 32'h0);
        step(1'b1, 1'b0, 32'h8, 32'h0);
        chk("L3 v1", {31'h0, v3}, 32'h1);
        chk("L3 d1", d3, 32'h1);
        idle();
        chk("L3 d2", d3, 32'h2);
        idle();
        chk("L3 v3", {31'h0, v3}, 32'h1);
        chk("L3 d3", d3, 32'h3);
        idle();
        chk("L3 done", {31'h0, v3}, 32'h0);

        // Snapshot at latency 2
        step(1'b1, 1'b1, 32'h20, 32'h5);
        step(1'b1, 1'b0, 32'h20, 32'h0);
        step(1'b1, 1'b1, 32'h20, 32'hA);
        chk("snap valid", {31'h0, v2}, 32'h1);
        chk("snap data", d2, 32'h5);
        chk("snap wrack", {31'h0, a2}, 32'h1);
        chk("snap err", {31'h0, e2}, 32'h0);
        step(1'b1, 1'b0, 32'h20, 32'h0);
        idle();
        chk("snap new valid", {31'h0, v2}, 32'h1);
        chk("snap new data", d2, 32'hA);

        // Reset mid-flight at latency 4
        step(1'b1, 1'b1, 32'h40, 32'h12345678);
        idle();
        idle();
        idle();
        chk("pre-reset L4 data", d4, 32'hA);
        step(1'b1, 1'b0, 32'h40, 32'h0);
        step(1'b1, 1'b0, 32'h44, 32'h0);
        reset = 1'b1;
        #1;
        chk("async rst data", d4, 32'h0);
        chk("async rst flags", {29'h0, v4, a4, e4}, 32'h0);
        chk("async rst L1", {d1[28:0], v1, a1, e1}, 32'h0);
        idle();
        idle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            chk("post-rst no valid", {31'h0, v4}, 32'h0);
        end
        step(1'b1, 1'b0, 32'h40, 32'h0);
        idle();
        idle();
        idle();
        chk("kept valid", {31'h0, v4}, 32'h1);
        chk("kept data", d4, 32'h12345678);

        // Idle hold
        step(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 20; i++) begin
            idle();
            chk("idle flags", {29'h0, v1, a1, e1}, 32'h0);
            chk("idle hold", d1, 32'hDEADBEEF);
        end

        // Randomized traffic, with occasional resets and boundary addresses
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 11))
                0: begin
                    ra = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                    ra[1:0] = 2'($urandom_range(1, 3));
                end
                1: begin
                    ra = $urandom;
                    if (ra[31:10] == 22'h0) ra[10] = 1'b1;
                end
                2: ra = 32'h3FC;
                3: ra = 32'h400;
                default: ra = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                idle();
                reset = 1'b0;
            end
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4, ra, $urandom);
        end
        for (int i = 0; i < 6; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
